// File: rtl/instruction_fetch_pkg.sv
// Shared processor definitions used by the fetch stage.
`timescale 1ns/1ps
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [3:0]  HALT_OPCODE = 4'b1111;
    localparam int unsigned PC_INC      = 4;

endpackage

// File: rtl/instruction_fetch_fetch_buffer.sv
// Two-entry instruction FIFO; each entry carries the word and the PC it came from.
`timescale 1ns/1ps
module fetch_buffer #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic               pop,
    input  logic               flush,
    output logic [1:0]         count,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc
);

    logic [INSTR_W-1:0] instr_q [2];
    logic [ADDR_W-1:0]  pc_q    [2];
    logic               rd_ptr;
    logic               wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= push_instr;
                pc_q[wr_ptr]    <= push_pc;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_instr = instr_q[rd_ptr];
    assign head_pc    = pc_q[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues ROM reads, buffers returned words, handles redirects and HALT.
`timescale 1ns/1ps
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Enable,
    output logic               IMemRdEn,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic [INSTR_W-1:0] IMemRdData,
    input  logic               BranchTaken,
    input  logic [ADDR_W-1:0]  BranchTarget,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic [3:0]         OpCode,
    output logic               Halted
);

    fetch_state_e      state, nxt_state;
    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [1:0]        count;
    logic              xfer, redirect, halt_xfer, pop, push, flush, room;
    logic [2:0]        occ_next;

    assign InstrValid = (count != 2'd0);
    assign OpCode     = Instr[INSTR_W-1 -: 4];
    assign IMemAddr   = pc;

    // A redirect outranks everything else, including a HALT sitting at the head.
    assign xfer      = InstrValid && InstrReady;
    assign redirect  = BranchTaken && (state == RUN);
    assign halt_xfer = xfer && (OpCode == HALT_OPCODE) && (state == RUN) && !redirect;
    assign pop       = xfer && !redirect;
    assign push      = inflight && !redirect && !halt_xfer;
    assign flush     = redirect || halt_xfer;
    assign occ_next  = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign room      = (occ_next < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (Enable) nxt_state = RUN;
            RUN:     if (halt_xfer) nxt_state = HALT;
            HALT:    nxt_state = HALT;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        IMemRdEn = 1'b0;
        Halted   = 1'b0;
        case (state)
            RUN:     IMemRdEn = Enable && !BranchTaken && !halt_xfer && room;
            HALT:    Halted   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            if (redirect)
                pc <= BranchTarget;
            else if (IMemRdEn)
                pc <= pc + ADDR_W'(PC_INC);
            inflight <= IMemRdEn;
        end
    end

    // The word landing this cycle belongs to the address issued last cycle.
    fetch_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_instr (IMemRdData),
        .push_pc    (pc - ADDR_W'(PC_INC)),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head_instr (Instr),
        .head_pc    (InstrPC)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC scoreboard on the decode side.
`timescale 1ns/1ps
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        Enable;
    logic        IMemRdEn;
    logic [31:0] IMemAddr;
    logic [31:0] IMemRdData;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic [3:0]  OpCode;
    logic        Halted;

    int          total = 0;
    int          bad   = 0;
    logic        halt_on = 1'b0;
    logic [31:0] exp_q [$];

    instruction_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Enable       (Enable),
        .IMemRdEn     (IMemRdEn),
        .IMemAddr     (IMemAddr),
        .IMemRdData   (IMemRdData),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .OpCode       (OpCode),
        .Halted       (Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        if (halt_on && a == 32'h8) return 32'hF000_0000;
        return a + 32'h100;
    endfunction

    always @(posedge clk)
        if (IMemRdEn) IMemRdData <= rom_f(IMemAddr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Checks any decode transfer against the scoreboard, then advances one cycle.
    task automatic cyc();
        @(negedge clk);
        if (InstrValid && InstrReady && !BranchTaken) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL xfer_unexpected: got pc %0h want none", InstrPC);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("xfer_pc", InstrPC, e);
                chk("xfer_instr", Instr, rom_f(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_rden", IMemRdEn, 0);
        chk("rst_valid", InstrValid, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_instr", Instr, 0);
        chk("rst_instrpc", InstrPC, 0);
        chk("rst_opcode", OpCode, 0);
        chk("rst_addr", IMemAddr, 0);
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    initial begin
        rst_n = 1'b0; Enable = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        InstrReady = 1'b0; IMemRdData = '0;
        repeat (3) cyc();
        check_reset();

        // Streaming from reset
        rst_n = 1'b1; Enable = 1'b1; InstrReady = 1'b1;
        #1 chk("idle_rden", IMemRdEn, 0);
        cyc();
        push_seq(32'h0, 16);
        chk("first_rden", IMemRdEn, 1);
        chk("first_addr", IMemAddr, 32'h0);
        cyc();
        chk("lat_valid0", InstrValid, 0);
        chk("second_addr", IMemAddr, 32'h4);
        cyc();
        chk("lat_valid1", InstrValid, 1);
        chk("lat_pc", InstrPC, 32'h0);
        repeat (5) cyc();

        // Backpressure: fetching stops at two buffered words, head stays put
        InstrReady = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rden", IMemRdEn, 0);
            chk("bp_valid", InstrValid, 1);
            chk("bp_pc", InstrPC, 32'h14);
            chk("bp_instr", Instr, 32'h114);
            cyc();
        end
        InstrReady = 1'b1;
        repeat (6) cyc();

        // Redirect with the buffer full
        InstrReady = 1'b0;
        repeat (3) cyc();
        chk("full_valid", InstrValid, 1);
        BranchTaken = 1'b1; BranchTarget = 32'h40;
        #1 chk("br_rden", IMemRdEn, 0);
        push_seq(32'h40, 8);
        cyc();
        BranchTaken = 1'b0; InstrReady = 1'b1;
        #1;
        chk("br_valid1", InstrValid, 0);
        chk("br_rden1", IMemRdEn, 1);
        chk("br_addr1", IMemAddr, 32'h40);
        cyc();
        chk("br_valid2", InstrValid, 0);
        cyc();
        chk("br_valid3", InstrValid, 1);
        chk("br_pc3", InstrPC, 32'h40);
        repeat (4) cyc();

        // Redirect coinciding with a transfer: the transfer is dropped
        chk("xb_valid", InstrValid, 1);
        BranchTaken = 1'b1; BranchTarget = 32'h200;
        push_seq(32'h200, 8);
        cyc();
        BranchTaken = 1'b0;
        chk("xb_valid1", InstrValid, 0);
        cyc();
        chk("xb_valid2", InstrValid, 0);
        cyc();
        chk("xb_valid3", InstrValid, 1);
        chk("xb_pc3", InstrPC, 32'h200);
        repeat (2) cyc();

        // HALT at 0x8
        halt_on = 1'b1;
        BranchTaken = 1'b1; BranchTarget = 32'h0;
        push_seq(32'h0, 3);
        cyc();
        BranchTaken = 1'b0;
        repeat (4) cyc();
        chk("halt_pc", InstrPC, 32'h8);
        chk("halt_opcode", OpCode, 4'hF);
        chk("halt_rden_x", IMemRdEn, 0);
        cyc();
        chk("halted", Halted, 1);
        chk("halt_valid", InstrValid, 0);
        chk("halt_rden", IMemRdEn, 0);
        BranchTaken = 1'b1; BranchTarget = 32'h100;
        #1 chk("halt_br_rden", IMemRdEn, 0);
        cyc();
        BranchTaken = 1'b0;
        repeat (3) cyc();
        chk("halt_hold", Halted, 1);
        chk("halt_hold_valid", InstrValid, 0);
        chk("halt_hold_rden", IMemRdEn, 0);
        chk("sb_drained", exp_q.size(), 0);

        // Reset out of HALT, then PC wrap across the top of the address space
        halt_on = 1'b0;
        rst_n = 1'b0;
        #1 check_reset();
        cyc();
        rst_n = 1'b1;
        cyc();
        BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFF8;
        push_seq(32'hFFFF_FFF8, 5);
        cyc();
        BranchTaken = 1'b0;
        #1;
        chk("wrap_addr0", IMemAddr, 32'hFFFF_FFF8);
        cyc();
        chk("wrap_addr1", IMemAddr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_addr2", IMemAddr, 32'h0);
        repeat (4) cyc();

        // Mid-stream reset right after an issued fetch
        chk("pre_rst_rden", IMemRdEn, 1);
        cyc();
        rst_n = 1'b0;
        #1 check_reset();
        cyc();
        rst_n = 1'b1;
        push_seq(32'h0, 2);
        #1 chk("rr_idle_rden", IMemRdEn, 0);
        chk("rr_valid0", InstrValid, 0);
        cyc();
        chk("rr_rden", IMemRdEn, 1);
        chk("rr_valid1", InstrValid, 0);
        cyc();
        chk("rr_valid2", InstrValid, 0);
        cyc();
        chk("rr_valid3", InstrValid, 1);
        chk("rr_pc3", InstrPC, 32'h0);
        cyc();
        cyc();
        InstrReady = 1'b0;
        chk("rr_drained", exp_q.size(), 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
